pulse_gen_multi: RTL and testbench

Parametrised, synthesizable multi-channel pulse generator: the successor to the single fixed-width pulse model. Each of CHANNELS channels produces, on trigger, a registered pulse of programmable width in clock cycles. A channel runs either one-shot or periodic with a programmable period, and can be aborted. It sits beside the shared clock source in the timing/stimulus subsystem and drives strobes to downstream blocks.

---
 rtl/pulse_gen_pkg.sv | 14 +
 rtl/pulse_channel.sv | 131 +++++++++++++
 rtl/pulse_gen_multi.sv | 50 +++++
 tb/tb_pulse_gen_multi.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_gen_pkg.sv
// Shared types and constants for the multi-channel pulse generator.
// Optional feature macro: PULSE_GEN_COUNT_EN (per-channel completed-pulse counters).
package pulse_gen_pkg;

  typedef enum logic [1:0] {
    PG_IDLE,
    PG_HIGH,
    PG_LOW
  } pg_state_t;

  localparam logic PG_ONESHOT  = 1'b0;
  localparam logic PG_PERIODIC = 1'b1;

endpackage

// File: rtl/pulse_channel.sv
// One pulse channel: IDLE/HIGH/LOW FSM, cycle down-counter and config latched at trigger.
// Optional feature macro: PULSE_GEN_COUNT_EN adds a wrapping completed-pulse counter.
module pulse_channel
  import pulse_gen_pkg::*;
#(
  parameter int unsigned CNT_W = 8
`ifdef PULSE_GEN_COUNT_EN
  ,
  parameter int unsigned COUNT_W = 16
`endif
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             trigger,
  input  logic             stop,
  input  logic             mode,
  input  logic [CNT_W-1:0] width,
  input  logic [CNT_W-1:0] period,
  output logic             pulse,
  output logic             busy
`ifdef PULSE_GEN_COUNT_EN
  ,
  output logic [COUNT_W-1:0] pulse_count
`endif
);

  pg_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] wid_q, wid_d;
  logic [CNT_W-1:0] low_q, low_d;
  logic [CNT_W-1:0] w_eff, l_eff;
  logic             mode_q, mode_d;
  logic             pulse_q, busy_q;
  logic             done;

  // Low time is P_eff - W_eff; when period <= width, P_eff = W_eff + 1 so the low time is 1.
  // Computing it this way avoids the W_eff + 1 overflow at the top of the range.
  always_comb begin
    w_eff = (width == '0) ? CNT_W'(1) : width;
    l_eff = (period > w_eff) ? (period - w_eff) : CNT_W'(1);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wid_d   = wid_q;
    low_d   = low_q;
    mode_d  = mode_q;
    done    = 1'b0;
    if (stop) begin
      state_d = PG_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        PG_IDLE: begin
          if (trigger) begin
            state_d = PG_HIGH;
            mode_d  = mode;
            wid_d   = w_eff;
            low_d   = l_eff;
            cnt_d   = w_eff - CNT_W'(1);
          end
        end
        PG_HIGH: begin
          if (cnt_q == '0) begin
            state_d = PG_LOW;
            cnt_d   = low_q - CNT_W'(1);
            done    = 1'b1;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        PG_LOW: begin
          if (cnt_q == '0) begin
            if (mode_q == PG_PERIODIC) begin
              state_d = PG_HIGH;
              cnt_d   = wid_q - CNT_W'(1);
            end else begin
              state_d = PG_IDLE;
            end
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_d = PG_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs are flopped from the next state so they change on the same edge as the FSM.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= PG_IDLE;
      cnt_q   <= '0;
      wid_q   <= '0;
      low_q   <= '0;
      mode_q  <= 1'b0;
      pulse_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wid_q   <= wid_d;
      low_q   <= low_d;
      mode_q  <= mode_d;
      pulse_q <= (state_d == PG_HIGH);
      busy_q  <= (state_d != PG_IDLE);
    end
  end

  assign pulse = pulse_q;
  assign busy  = busy_q;

`ifdef PULSE_GEN_COUNT_EN
  logic [COUNT_W-1:0] count_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (done) begin
      count_q <= count_q + COUNT_W'(1);
    end
  end

  assign pulse_count = count_q;
`endif

endmodule

// File: rtl/pulse_gen_multi.sv
// Multi-channel pulse generator: CHANNELS independent pulse_channel instances sharing config.
// Optional feature macro: PULSE_GEN_COUNT_EN exposes packed per-channel pulse counters.
module pulse_gen_multi #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned CNT_W    = 8
`ifdef PULSE_GEN_COUNT_EN
  ,
  parameter int unsigned COUNT_W  = 16
`endif
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [CHANNELS-1:0] trigger,
  input  logic [CHANNELS-1:0] stop,
  input  logic                mode,
  input  logic [CNT_W-1:0]    width,
  input  logic [CNT_W-1:0]    period,
  output logic [CHANNELS-1:0] pulse,
  output logic [CHANNELS-1:0] busy
`ifdef PULSE_GEN_COUNT_EN
  ,
  output logic [CHANNELS*COUNT_W-1:0] pulse_count
`endif
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    pulse_channel #(
      .CNT_W   (CNT_W)
`ifdef PULSE_GEN_COUNT_EN
      ,
      .COUNT_W (COUNT_W)
`endif
    ) u_ch (
      .clock       (clock),
      .reset       (reset),
      .trigger     (trigger[i]),
      .stop        (stop[i]),
      .mode        (mode),
      .width       (width),
      .period      (period),
      .pulse       (pulse[i]),
      .busy        (busy[i])
`ifdef PULSE_GEN_COUNT_EN
      ,
      .pulse_count (pulse_count[i*COUNT_W +: COUNT_W])
`endif
    );
  end

endmodule

// File: tb/tb_pulse_gen_multi.sv
// Scoreboard bench for pulse_gen_multi: expected output-change events are queued by the stimulus
// and checked by an independent monitor. Counter checks need PULSE_GEN_COUNT_EN.
module tb_pulse_gen_multi;

  localparam int unsigned CHANNELS = 4;
  localparam int unsigned CNT_W    = 8;
`ifdef PULSE_GEN_COUNT_EN
  localparam int unsigned COUNT_W  = 4;
`endif

  logic                clock;
  logic                reset;
  logic [CHANNELS-1:0] trigger;
  logic [CHANNELS-1:0] stop;
  logic                mode;
  logic [CNT_W-1:0]    width;
  logic [CNT_W-1:0]    period;
  logic [CHANNELS-1:0] pulse;
  logic [CHANNELS-1:0] busy;
`ifdef PULSE_GEN_COUNT_EN
  logic [CHANNELS*COUNT_W-1:0] pulse_count;
`endif

  pulse_gen_multi #(
    .CHANNELS (CHANNELS),
    .CNT_W    (CNT_W)
`ifdef PULSE_GEN_COUNT_EN
    ,
    .COUNT_W  (COUNT_W)
`endif
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .trigger     (trigger),
    .stop        (stop),
    .mode        (mode),
    .width       (width),
    .period      (period),
    .pulse       (pulse),
    .busy        (busy)
`ifdef PULSE_GEN_COUNT_EN
    ,
    .pulse_count (pulse_count)
`endif
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // An event is the (pulse, busy) value expected after the edge whose count is cyc.
  typedef struct {
    int         cyc;
    logic [3:0] p;
    logic [3:0] b;
  } ev_t;

  ev_t        sb[$];
  int         cyc    = 0;
  int         checks = 0;
  int         errors = 0;
  logic [3:0] prev_p = '0;
  logic [3:0] prev_b = '0;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    ev_t e;
    if (pulse !== prev_p || busy !== prev_b) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_change cyc=%0d pulse=%b busy=%b required=no change",
                 cyc, pulse, busy);
      end else begin
        e = sb.pop_front();
        if (e.cyc != cyc || e.p !== pulse || e.b !== busy) begin
          errors++;
          $display("FAIL event actual cyc=%0d pulse=%b busy=%b required cyc=%0d pulse=%b busy=%b",
                   cyc, pulse, busy, e.cyc, e.p, e.b);
        end
      end
      prev_p = pulse;
      prev_b = busy;
    end
  end

  task automatic push_ev(input int c, input logic [3:0] p, input logic [3:0] b);
    ev_t e;
    e.cyc = c;
    e.p   = p;
    e.b   = b;
    sb.push_back(e);
  endtask

  task automatic at_cyc(input int c);
    while (cyc < c) @(negedge clock);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clock);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain actual=%0d events outstanding required=0", sb.size());
      sb.delete();
    end
    repeat (3) @(negedge clock);
  endtask

  task automatic cfg(input logic [7:0] w, input logic [7:0] p, input logic m);
    width  = w;
    period = p;
    mode   = m;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    reset   = 1'b1;
    trigger = '0;
    stop    = '0;
    cfg(8'd0, 8'd0, 1'b0);
    repeat (3) @(negedge clock);
    check("reset_pulse", 32'(pulse), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
`ifdef PULSE_GEN_COUNT_EN
    check("reset_count", 32'(pulse_count), 32'h0);
`endif
    reset = 1'b0;

    // One-shot w=3 p=8 on ch0, then a trigger on the edge where busy has just dropped.
    cfg(8'd3, 8'd8, 1'b0);
    @(negedge clock);
    k = cyc + 1;
    push_ev(k, 4'b0001, 4'b0001);
    push_ev(k + 3, 4'b0000, 4'b0001);
    push_ev(k + 8, 4'b0000, 4'b0000);
    push_ev(k + 9, 4'b0001, 4'b0001);
    push_ev(k + 12, 4'b0000, 4'b0001);
    push_ev(k + 17, 4'b0000, 4'b0000);
    trigger = 4'b0001;
    @(negedge clock);
    trigger = '0;
    at_cyc(k + 8);
    trigger = 4'b0001;
    @(negedge clock);
    trigger = '0;
    drain(40);

    // Periodic w=2 p=5 on ch1, stopped during the third high phase.
    cfg(8'd2, 8'd5, 1'b1);
    @(negedge clock);
    k = cyc + 1;
    push_ev(k, 4'b0010, 4'b0010);
    push_ev(k + 2, 4'b0000, 4'b0010);
    push_ev(k + 5, 4'b0010, 4'b0010);
    push_ev(k + 7, 4'b0000, 4'b0010);
    push_ev(k + 10, 4'b0010, 4'b0010);
    push_ev(k + 11, 4'b0000, 4'b0000);
    trigger = 4'b0010;
    @(negedge clock);
    trigger = '0;
    at_cyc(k + 10);
    stop = 4'b0010;
    @(negedge clock);
    stop = '0;
    drain(30);
`ifdef PULSE_GEN_COUNT_EN
    check("count_ch1_after_stop", 32'(pulse_count[1*COUNT_W +: COUNT_W]), 32'd2);
`endif

    // Zero width and period clamp to W_eff=1, P_eff=2.
    cfg(8'd0, 8'd0, 1'b0);
    @(negedge clock);
    k = cyc + 1;
    push_ev(k, 4'b1000, 4'b1000);
    push_ev(k + 1, 4'b0000, 4'b1000);
    push_ev(k + 2, 4'b0000, 4'b0000);
    trigger = 4'b1000;
    @(negedge clock);
    trigger = '0;
    drain(20);

    // Config changes and a retrigger while ch2 is busy must have no effect.
    cfg(8'd3, 8'd8, 1'b0);
    @(negedge clock);
    k = cyc + 1;
    push_ev(k, 4'b0100, 4'b0100);
    push_ev(k + 3, 4'b0000, 4'b0100);
    push_ev(k + 8, 4'b0000, 4'b0000);
    trigger = 4'b0100;
    @(negedge clock);
    cfg(8'd7, 8'd20, 1'b1);
    @(negedge clock);
    trigger = '0;
    drain(30);

    // Trigger and stop together in IDLE: nothing starts.
    cfg(8'd3, 8'd8, 1'b0);
    @(negedge clock);
    trigger = 4'b0001;
    stop    = 4'b0001;
    @(negedge clock);
    trigger = '0;
    stop    = '0;
    repeat (4) @(negedge clock);
    check("trig_stop_busy", 32'(busy), 32'h0);
    check("trig_stop_pulse", 32'(pulse), 32'h0);

    // All channels together, w=1 p=2.
    cfg(8'd1, 8'd2, 1'b0);
    @(negedge clock);
    k = cyc + 1;
    push_ev(k, 4'b1111, 4'b1111);
    push_ev(k + 1, 4'b0000, 4'b1111);
    push_ev(k + 2, 4'b0000, 4'b0000);
    trigger = 4'b1111;
    @(negedge clock);
    trigger = '0;
    drain(20);

    // Maximum width: P_eff = 256, so exactly one low cycle.
    cfg(8'd255, 8'd10, 1'b0);
    @(negedge clock);
    k = cyc + 1;
    push_ev(k, 4'b0010, 4'b0010);
    push_ev(k + 255, 4'b0000, 4'b0010);
    push_ev(k + 256, 4'b0000, 4'b0000);
    trigger = 4'b0010;
    @(negedge clock);
    trigger = '0;
    drain(300);

    // Maximum period with a long width.
    cfg(8'd200, 8'd255, 1'b0);
    @(negedge clock);
    k = cyc + 1;
    push_ev(k, 4'b0100, 4'b0100);
    push_ev(k + 200, 4'b0000, 4'b0100);
    push_ev(k + 255, 4'b0000, 4'b0000);
    trigger = 4'b0100;
    @(negedge clock);
    trigger = '0;
    drain(300);

    // Async reset mid-high, then a trigger honoured on the first edge after release.
    cfg(8'd5, 8'd10, 1'b0);
    @(negedge clock);
    k = cyc + 1;
    push_ev(k, 4'b0001, 4'b0001);
    push_ev(k + 3, 4'b0000, 4'b0000);
    trigger = 4'b0001;
    @(negedge clock);
    trigger = '0;
    at_cyc(k + 2);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_pulse", 32'(pulse), 32'h0);
    check("async_reset_busy", 32'(busy), 32'h0);
`ifdef PULSE_GEN_COUNT_EN
    check("async_reset_count", 32'(pulse_count), 32'h0);
`endif
    @(negedge clock);
    cfg(8'd2, 8'd4, 1'b0);
    reset = 1'b0;
    push_ev(k + 4, 4'b1000, 4'b1000);
    push_ev(k + 6, 4'b0000, 4'b1000);
    push_ev(k + 8, 4'b0000, 4'b0000);
    trigger = 4'b1000;
    @(negedge clock);
    trigger = '0;
    drain(20);

    // Sixteen complete periodic pulses on ch2; with a 4-bit counter it wraps 15 -> 0.
    cfg(8'd1, 8'd2, 1'b1);
    @(negedge clock);
    k = cyc + 1;
    for (int j = 0; j < 16; j++) begin
      push_ev(k + 2 * j, 4'b0100, 4'b0100);
      push_ev(k + 2 * j + 1, 4'b0000, 4'b0100);
    end
    push_ev(k + 32, 4'b0000, 4'b0000);
    trigger = 4'b0100;
    @(negedge clock);
    trigger = '0;
    at_cyc(k + 29);
`ifdef PULSE_GEN_COUNT_EN
    check("count_ch2_at_15", 32'(pulse_count[2*COUNT_W +: COUNT_W]), 32'd15);
`endif
    at_cyc(k + 31);
`ifdef PULSE_GEN_COUNT_EN
    check("count_ch2_wrap", 32'(pulse_count[2*COUNT_W +: COUNT_W]), 32'd0);
`endif
    stop = 4'b0100;
    @(negedge clock);
    stop = '0;
    drain(20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
